instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ARQ, default 16: instruction width in bits.
REQ-002 Parameter AW, default 13: instruction address width, equal to the 13-bit jump address field of JEQ/J.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  level; leaves IDLE and begins fetching.
REQ-006 stall  input  1  hold request from the decode/hazard logic.
REQ-007 branch_taken  input  1  redirect request for a resolved JEQ/J.
REQ-008 branch_addr  input  AW  redirect target.
REQ-009 imem_addr  output  AW  instruction memory address, equal to PC.
REQ-010 imem_rdata  input  ARQ  instruction memory data, combinational read of imem_addr in the same cycle.
REQ-011 instr_out  output  ARQ  IF/ID instruction register; feeds the instruction decoder input directly.
REQ-012 pc_out  output  AW  address of the instruction held in instr_out.
REQ-013 valid_out  output  1  instr_out holds a live instruction.
REQ-014 fetch_cnt  output  16  count of instructions latched valid, saturating.

Function
REQ-015 The FSM SHALL have two states: IDLE and RUN.
REQ-016 IDLE -> RUN on a rising edge with start=1; RUN SHALL remain RUN until rst; start is ignored in RUN.
REQ-017 In IDLE: PC, instr_out, pc_out, and fetch_cnt SHALL hold; valid_out SHALL be 0; stall and branch_taken SHALL be ignored.
REQ-018 The first fetch SHALL occur in the cycle after the IDLE->RUN edge, with imem_addr=0.
REQ-019 In RUN, per-edge priority SHALL be rst > branch_taken > stall > normal.
REQ-020 Normal (RUN, no stall, no branch): instr_out<=imem_rdata; pc_out<=PC; valid_out<=1; PC<=PC+1.
REQ-021 PC increment SHALL be modulo 2^AW (13'h1FFF+1 -> 13'h0000) with no flag or stall.
REQ-022 Stall (RUN, stall=1, branch_taken=0): PC, instr_out, pc_out, valid_out, and fetch_cnt SHALL hold unchanged.
REQ-023 Branch (RUN, branch_taken=1): PC<=branch_addr; valid_out<=0; instr_out<=0; pc_out holds. This SHALL apply regardless of stall, squashing the instruction currently in IF/ID.
REQ-024 After a branch, the next edge without stall SHALL latch imem_rdata at branch_addr: one-cycle redirect penalty, exactly one bubble.
REQ-025 Back-to-back branch_taken on consecutive edges: each edge SHALL reload PC; the last target wins; valid_out stays 0 throughout.
REQ-026 fetch_cnt SHALL increment on every edge that sets valid_out<=1 and saturate at 16'hFFFF.
REQ-027 imem_addr SHALL be combinationally equal to PC in all states.
REQ-028 Downstream SHALL qualify instr_out with valid_out; instr_out=0 with valid_out=0 is a bubble, not SET R0.

Reset
REQ-029 On a rising edge with rst=1, in any state including mid-stall or mid-branch: state<=IDLE; PC<=0; instr_out<=0; pc_out<=0; valid_out<=0; fetch_cnt<=0.
REQ-030 rst SHALL override start, stall, and branch_taken in the same cycle.
REQ-031 No output SHALL change asynchronously to clk.

Verification
REQ-032 Startup: rst 2 cycles, start=1, imem[0..2]=16'h2400,16'h4A10,16'hE005 -> valid_out rises 1 cycle after the RUN edge; instr_out/pc_out sequence 2400/0, 4A10/1, E005/2; fetch_cnt=3.
REQ-033 Stall: stall=1 for 3 cycles while instr_out=16'h4A10, pc=1 -> all outputs frozen for 3 cycles; on release, pc_out=2, no instruction lost or duplicated.
REQ-034 Branch with stall: branch_taken=1, branch_addr=13'h0100, stall=1 in the same cycle -> next cycle valid_out=0, imem_addr=0x100; following cycle instr_out=imem[0x100], pc_out=0x100.
REQ-035 Wrap: preload via branch to 13'h1FFE, run 3 cycles -> pc_out sequence 1FFE, 1FFF, 0000.
REQ-036 Mid-run reset: assert rst during RUN with stall=1 and branch_taken=1 -> all outputs reach reset values next cycle; FSM in IDLE; no fetch until start.
REQ-037 Saturation: force fetch_cnt to 16'hFFFE, run 3 valid cycles -> fetch_cnt reads FFFF and holds.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, IF/ID instruction register and a two-state
// IDLE/RUN controller with branch redirect, stall hold and a saturating fetch counter.
module instr_fetch #(
   parameter int ARQ = 16,
   parameter int AW  = 13
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           stall,
   input  logic           branch_taken,
   input  logic [AW-1:0]  branch_addr,
   output logic [AW-1:0]  imem_addr,
   input  logic [ARQ-1:0] imem_rdata,
   output logic [ARQ-1:0] instr_out,
   output logic [AW-1:0]  pc_out,
   output logic           valid_out,
   output logic [15:0]    fetch_cnt,
   output logic           dbg_state
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]     state_q, state_d;
   logic [AW-1:0]  pc_q, pc_d;
   logic [ARQ-1:0] instr_q, instr_d;
   logic [AW-1:0]  pcout_q, pcout_d;
   logic           valid_q, valid_d;
   logic [15:0]    cnt_q, cnt_d;

   // Downstream qualifies instr_out with valid_out: a zero word with valid_out=0 is a
   // bubble. There is no ready; stall is the only back-pressure and freezes IF/ID.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pcout_d = pcout_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            valid_d = 1'b0;
            if (start) state_d = S_RUN;
         end
         default: begin
            if (branch_taken) begin
               // Redirect squashes whatever sits in IF/ID, even while stalled.
               pc_d    = branch_addr;
               instr_d = '0;
               valid_d = 1'b0;
            end else if (!stall) begin
               instr_d = imem_rdata;
               pcout_d = pc_q;
               valid_d = 1'b1;
               pc_d    = pc_q + AW'(1);
               if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         instr_q <= '0;
         pcout_q <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pcout_q <= pcout_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign imem_addr = pc_q;
   assign instr_out = instr_q;
   assign pc_out    = pcout_q;
   assign valid_out = valid_q;
   assign fetch_cnt = cnt_q;
   assign dbg_state = state_q[0];

endmodule
